// File: rtl/hex_scan_driver_if.sv
// Avalon-MM register port of the scanned hex display driver.
interface hex_scan_driver_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment driver: per-digit registers, slot prescaler
// with a leading blank window, registered pin outputs with optional inversion.
module hex_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_scan_driver_if.slave      bus,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  // Pin-level "off" values; XOR with these applies the polarity.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [7:0]            digit_q [NUM_DIGITS];
  logic                  en_q;
  logic                  dec_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            idx_q;
  logic                  wr;
  logic [7:0]            cur;
  logic [NUM_DIGITS-1:0] sel;
  logic [6:0]            pat;
  logic                  active;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] dig_q;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
    endcase
  endfunction

  assign wr = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      en_q  <= 1'b0;
      dec_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      if (wr) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (bus.address == 4'(i)) digit_q[i] <= bus.writedata[7:0];
        if (bus.address == 4'd8) begin
          en_q  <= bus.writedata[0];
          dec_q <= bus.writedata[1];
        end
      end
      // Scan advances on the pre-edge enable; a disabled scan parks at digit 0.
      if (!en_q) begin
        cnt_q <= '0;
        idx_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cur = '0;
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur    = digit_q[i];
        sel[i] = 1'b1;
      end
    end
    pat    = dec_q ? hex_font(cur[3:0]) : cur[6:0];
    active = en_q && (cnt_q >= CNT_BLANK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= (active ? pat : 7'h00) ^ SEG_OFF;
      dp_q  <= (active && cur[7]) ^ DP_OFF;
      dig_q <= (active ? sel : '0) ^ DIG_OFF;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_q;

  always_comb begin
    bus.readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bus.address == 4'(i)) bus.readdata[7:0] = digit_q[i];
    if (bus.address == 4'd8) bus.readdata[1:0] = {dec_q, en_q};
    if (bus.address == 4'd9) bus.readdata[2:0] = idx_q;
  end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Avalon-MM slave that time-multiplexes up to 8 seven-segment digits onto one shared segment bus plus per-digit select lines.
- Sits downstream of the CPU's single-digit hex PIO. It replaces the static 7-bit segment drive with a scanned multi-digit display, holding per-digit patterns or hex nibbles in registers.
- A prescaler sets the per-digit dwell time. A blanking window at the start of each slot prevents ghosting.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digit selects inactive; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 inverts seg and dp at the pins.
- DIG_ACTIVE_LOW, 1, 1 inverts dig_sel at the pins.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  4  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational on address.
- seg  out  7  segment lines; bit0=a … bit6=g.
- dp  out  1  decimal point line.
- dig_sel  out  NUM_DIGITS  digit select, one-hot when active.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising clk edge.
- Register map:
  - Addresses 0..NUM_DIGITS-1 (DIGITn, 8 bits): [6:0] raw segment pattern, [7] dp. In decode mode, [3:0] is a hex nibble.
  - Address 8 (CTRL): [0] enable, [1] decode.
  - Address 9 (STATUS, read-only): [2:0] current digit index.
- Writes occur when chipselect && !write_n; the register updates at that clk edge.
- Writes to 9–15, and to digit addresses ≥ NUM_DIGITS, are ignored.
- Reads: readdata is zero-extended. Unused and unimplemented addresses read 0.
- Reset effects:
  - All DIGIT registers, CTRL, prescaler count cnt and index idx go to 0.
  - The output registers go to inactive levels: seg/dp all-off, dig_sel all-off, after polarity inversion.
  - Reset mid-slot aborts the scan immediately. The first slot after reset is digit 0, starting from cnt=0.
- Scan counter (while enable=1), each cycle:
  - if cnt == SCAN_DIV-1: cnt <= 0, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1;
  - else cnt <= cnt+1.
- enable=0: cnt and idx are forced to 0 every cycle. Re-enabling starts a fresh slot on digit 0.
- Output registers, updated every cycle from the pre-edge cnt/idx/registers (1-cycle latency):
  - active = enable && (cnt ≥ BLANK_CYCLES).
  - dig_sel_int = active ? onehot(idx) : 0.
  - seg_int = active ? pattern(DIGIT[idx]) : 0.
  - dp_int = active ? DIGIT[idx][7] : 0.
  - Each of these is inverted at the pin when its *_ACTIVE_LOW parameter = 1.
- Decode mode: pattern = hex font of [3:0], bits g..a:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- Raw mode: pattern = [6:0].
- Write to the digit currently shown: the new pattern appears on seg at the following edge, with no tearing of dig_sel.
- A CTRL write that clears enable makes the outputs inactive one edge after the write edge.
- NUM_DIGITS=1: idx is constant 0; the blanking window still applies each slot.

Test Plan:
- Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4, both polarities active-low.
- Reset and readback:
  - Assert reset_n=0 for 3 cycles → seg=0x7F, dp=1, dig_sel=4'hF.
  - Read addresses 0..9 → all 0.
  - Write DIGIT0=0xA5, then read → 0x000000A5.
  - Write address 5 (≥ NUM_DIGITS), then read 5 → 0.
- Raw scan: DIGIT0..3 = 0x01, 0x02, 0x04, 0x08, then CTRL=1.
  - Per 8-cycle slot: dig_sel stays 4'hF for 2 cycles, then 4'hE for 6 cycles with seg=0x7E.
  - Then digits 1, 2, 3 (dig_sel 4'hD/4'hB/4'h7) in turn, then wrap to digit 0.
  - STATUS tracks idx 0→3→0.
- Decode: CTRL=3, DIGIT2=0x83.
  - During slot 2 active window: seg=~0x4F=0x30, dp=0.
  - DIGIT2=0x0B → seg=~0x7C=0x03.
- Live update: during the active window of digit 1, write DIGIT1=0x7F → seg becomes 0x00 one edge after the write edge; dig_sel unchanged.
- Disable and reset mid-scan:
  - CTRL=0 in the middle of slot 3 → outputs inactive next edge. Re-enable → the slot starts on digit 0 with a 2-cycle blank.
  - Pulse reset_n=0 for 1 cycle mid-slot 2 → CTRL/DIGITs read 0, outputs inactive.
